if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Fetch stage upstream of the F->D pipeline register: owns the PC, issues one
//  instruction-memory request at a time, and holds each returned word until decode accepts it.
//  Drives instrF/pcF into the F->D register; fetch_stall tells the hazard unit to hold the pipe.
//  Accepts branch/jump/exception redirects from later stages.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   PC value loaded on reset
//  PC_W       32              PC / address width
//  INSTR_W    32              instruction word width
// PORTS
//  clk          in   1        clock, all state changes on posedge
//  rst          in   1        synchronous, active-high reset
//  stallF       in   1        decode not accepting; 1 = hold current instruction
//  pc_redirect  in   1        1-cycle pulse: discard current fetch, restart at pc_target
//  pc_target    in   PC_W     redirect destination, valid while pc_redirect=1
//  inst_req     out  1        memory request valid
//  inst_addr    out  PC_W     request address (= current PC)
//  inst_addr_ok in   1        memory accepted request this cycle
//  inst_data_ok in   1        read data valid this cycle
//  inst_rdata   in   INSTR_W  read data
//  instrF       out  INSTR_W  fetched instruction (to F->D register d input)
//  pcF          out  PC_W     PC of instrF
//  validF       out  1        instrF/pcF hold a usable instruction
//  fetch_stall  out  1        = ~validF; tells the hazard unit to stall F/D
//  adelF        out  1        instruction address error flag travelling with instrF
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, instrF=0, pcF=0, validF=0, adelF=0, cancel=0.
//    Reset also clears any request in flight; the memory is reset by the same rst.
//  - States: IDLE (request), WAIT (address accepted, awaiting data),
//    DONE (word buffered, presented to decode).
//  - IDLE: inst_req = ~pc_redirect, inst_addr = pc.
//    Request accepted (inst_req & inst_addr_ok) -> WAIT.
//  - WAIT: on inst_data_ok, if cancel=0: buffer inst_rdata -> instrF, pcF<=pc,
//    validF<=1, go to DONE. If cancel=1: drop the data, cancel<=0, go to IDLE.
//  - DONE: validF=1. When stallF=0: pc<=pc+4, validF<=0, go to IDLE.
//    When stallF=1: outputs stay unchanged.
//  - Minimum latency: 3 cycles from request to validF, with zero-wait memory
//    (addr_ok in the IDLE cycle, data_ok in the next cycle).
//    At most one outstanding request.
//  - pc_redirect takes priority over stallF and over data_ok in every state:
//    pc<=pc_target, validF<=0.
//    IDLE: no request that cycle, stay in IDLE.
//    WAIT: cancel<=1, except when data_ok arrives the same cycle; then drop the data, go to IDLE.
//    DONE: go to IDLE.
//  - PC arithmetic is modulo 2^PC_W; 32'hFFFF_FFFC + 4 wraps to 0.
//  - inst_addr_ok and inst_data_ok are ignored outside IDLE and WAIT respectively.
// CONFIGURATION
//  IF_ADDR_ERR_EN defined: if pc[1:0]!=0 in IDLE, no request is issued.
//  The stage goes directly to DONE next cycle with instrF=0 (NOP), pcF=pc, adelF=1.
//  Redirect and stall rules as above.
//  IF_ADDR_ERR_EN undefined: adelF is tied to 0, inst_addr[1:0] is forced to 0,
//  and PC low bits are not checked.
// STRUCTURE
//  - pipeline_pkg: RESET_PC default, NOP_INSTR=32'h0, fetch state enum
//    {IDLE, WAIT, DONE}, PC_INC=4.
//  - One sub-module, if_next_pc: combinational next-PC select
//    (redirect target / pc+4 / hold).
//  - The FSM and buffer stay in if_fetch_stage.
// TESTING
//  1 Reset, zero-wait memory returning 32'h2408_0001.
//    -> req at addr BFC00000; validF=1 on cycle 3; then pcF=BFC00004 on the next fetch.
//  2 stallF=1 for 5 cycles while in DONE.
//    -> instrF/pcF stable, no new inst_req, fetch_stall=0.
//  3 pc_redirect to 32'h8000_0100 while in WAIT; stale data returns 2 cycles later.
//    -> data dropped, validF stays 0, next req addr=80000100.
//  4 pc_redirect in the same cycle as inst_data_ok.
//    -> data dropped, IDLE next cycle, req at pc_target.
//  5 rst asserted in WAIT.
//    -> next cycle validF=0, inst_req=1 with addr=RESET_PC.
//  6 (IF_ADDR_ERR_EN) redirect to 32'h8000_0102.
//    -> no req, validF=1 with instrF=0, adelF=1, pcF=80000102.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline constants and the fetch FSM state type.
// Latency: none (declarations only). Backpressure: not applicable.
// Imported by if_fetch_stage and if_next_pc.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          PC_INC       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC select: a redirect target wins, then pc+4 on advance, otherwise the PC holds.
// Latency: purely combinational. Backpressure: hold is selected by the caller's advance input.
// The addition wraps modulo 2^PC_W.
module if_next_pc
    import pipeline_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pc_target,
    input  logic            redirect,
    input  logic            advance,
    output logic [PC_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        if (redirect)
            next_pc = pc_target;
        else if (advance)
            next_pc = pc + PC_W'(PC_INC);
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, issues one imem request at a time, and buffers the word for decode.
// Latency: 3 cycles from request to validF with zero-wait memory. Backpressure: stallF holds DONE.
// Optional IF_ADDR_ERR_EN: a misaligned PC produces a NOP with adelF set instead of a request.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int               PC_W     = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallF,
    input  logic               pc_redirect,
    input  logic [PC_W-1:0]    pc_target,
    output logic               inst_req,
    output logic [PC_W-1:0]    inst_addr,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    input  logic [INSTR_W-1:0] inst_rdata,
    output logic [INSTR_W-1:0] instrF,
    output logic [PC_W-1:0]    pcF,
    output logic               validF,
    output logic               fetch_stall,
    output logic               adelF
);

    fetch_state_t        state, state_nxt;
    logic [PC_W-1:0]     pc, pc_nxt;
    logic                cancel, cancel_nxt;
    logic [INSTR_W-1:0]  instr_nxt;
    logic [PC_W-1:0]     pcf_nxt;
    logic                valid_nxt, adel_nxt;
    logic                addr_err;

`ifdef IF_ADDR_ERR_EN
    assign addr_err  = |pc[1:0];
    assign inst_addr = pc;
`else
    assign addr_err  = 1'b0;
    assign inst_addr = {pc[PC_W-1:2], 2'b00};
`endif

    if_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc        (pc),
        .pc_target (pc_target),
        .redirect  (pc_redirect),
        .advance   ((state == DONE) && !stallF),
        .next_pc   (pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            cancel <= 1'b0;
            instrF <= '0;
            pcF    <= '0;
            validF <= 1'b0;
            adelF  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            cancel <= cancel_nxt;
            instrF <= instr_nxt;
            pcF    <= pcf_nxt;
            validF <= valid_nxt;
            adelF  <= adel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        instr_nxt  = instrF;
        pcf_nxt    = pcF;
        valid_nxt  = validF;
        adel_nxt   = adelF;
        inst_req   = 1'b0;
        case (state)
            IDLE: begin
                inst_req = !pc_redirect && !addr_err;
                if (!pc_redirect) begin
                    if (addr_err) begin
                        state_nxt = DONE;
                        instr_nxt = INSTR_W'(NOP_INSTR);
                        pcf_nxt   = pc;
                        valid_nxt = 1'b1;
                        adel_nxt  = 1'b1;
                    end else if (inst_addr_ok) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // A redirect with no data yet must swallow the in-flight response later.
                if (pc_redirect) begin
                    if (inst_data_ok) begin
                        state_nxt  = IDLE;
                        cancel_nxt = 1'b0;
                    end else begin
                        cancel_nxt = 1'b1;
                    end
                end else if (inst_data_ok) begin
                    if (cancel) begin
                        state_nxt  = IDLE;
                        cancel_nxt = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        instr_nxt = inst_rdata;
                        pcf_nxt   = pc;
                        valid_nxt = 1'b1;
                        adel_nxt  = 1'b0;
                    end
                end
            end
            DONE: begin
                if (pc_redirect || !stallF) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    adel_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fetch_stall = !validF;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the memory side is driven cycle by cycle from the tasks.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic        validF;
    logic        fetch_stall;
    logic        adelF;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stallF       (stallF),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .instrF       (instrF),
        .pcF          (pcF),
        .validF       (validF),
        .fetch_stall  (fetch_stall),
        .adelF        (adelF)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Zero-wait fetch: addr_ok in IDLE, data_ok next cycle; ends settled in DONE.
    task automatic fetch_word(input logic [31:0] w, input logic hold);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = w;
        stallF       = hold;
        tick();
        inst_data_ok = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1; stallF = 1'b0; pc_redirect = 1'b0; pc_target = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        tick(); tick();
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL reset_validF got %h exp 0", validF); end
        tests++; if (instrF !== 32'h0) begin fails++; $display("FAIL reset_instrF got %h exp 0", instrF); end
        tests++; if (pcF !== 32'h0) begin fails++; $display("FAIL reset_pcF got %h exp 0", pcF); end
        tests++; if (adelF !== 1'b0) begin fails++; $display("FAIL reset_adelF got %h exp 0", adelF); end
        tests++; if (fetch_stall !== 1'b1) begin fails++; $display("FAIL reset_fetch_stall got %h exp 1", fetch_stall); end
        rst = 1'b0;
        settle();
        tests++; if (inst_req !== 1'b1) begin fails++; $display("FAIL reset_req got %h exp 1", inst_req); end
        tests++; if (inst_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL reset_addr got %h exp bfc00000", inst_addr); end
    endtask

    task automatic test_first_fetch();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        settle();
        tests++; if (inst_req !== 1'b0) begin fails++; $display("FAIL wait_req got %h exp 0", inst_req); end
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL wait_validF got %h exp 0", validF); end
        tick();
        inst_data_ok = 1'b0;
        settle();
        tests++; if (validF !== 1'b1) begin fails++; $display("FAIL c3_validF got %h exp 1", validF); end
        tests++; if (instrF !== 32'h2408_0001) begin fails++; $display("FAIL c3_instrF got %h exp 24080001", instrF); end
        tests++; if (pcF !== 32'hBFC0_0000) begin fails++; $display("FAIL c3_pcF got %h exp bfc00000", pcF); end
        tests++; if (fetch_stall !== 1'b0) begin fails++; $display("FAIL c3_fetch_stall got %h exp 0", fetch_stall); end
        tick();
        tests++; if (inst_req !== 1'b1) begin fails++; $display("FAIL next_req got %h exp 1", inst_req); end
        tests++; if (inst_addr !== 32'hBFC0_0004) begin fails++; $display("FAIL next_addr got %h exp bfc00004", inst_addr); end
        fetch_word(32'h8C09_0010, 1'b1);
        tests++; if (pcF !== 32'hBFC0_0004) begin fails++; $display("FAIL second_pcF got %h exp bfc00004", pcF); end
        tests++; if (instrF !== 32'h8C09_0010) begin fails++; $display("FAIL second_instrF got %h exp 8c090010", instrF); end
    endtask

    task automatic test_stall();
        // Handshakes outside their states must be ignored while held.
        stallF = 1'b1; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (instrF !== 32'h8C09_0010) begin fails++; $display("FAIL stall%0d_instrF got %h exp 8c090010", i, instrF); end
            tests++; if (pcF !== 32'hBFC0_0004) begin fails++; $display("FAIL stall%0d_pcF got %h exp bfc00004", i, pcF); end
            tests++; if (inst_req !== 1'b0) begin fails++; $display("FAIL stall%0d_req got %h exp 0", i, inst_req); end
            tests++; if (fetch_stall !== 1'b0) begin fails++; $display("FAIL stall%0d_fetch_stall got %h exp 0", i, fetch_stall); end
        end
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; stallF = 1'b0;
        tick();
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL release_validF got %h exp 0", validF); end
        tests++; if (inst_addr !== 32'hBFC0_0008) begin fails++; $display("FAIL release_addr got %h exp bfc00008", inst_addr); end
    endtask

    task automatic test_redirect_wait();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; pc_redirect = 1'b1; pc_target = 32'h8000_0100;
        tick();
        pc_redirect = 1'b0; pc_target = '0;
        settle();
        tests++; if (inst_req !== 1'b0) begin fails++; $display("FAIL rw_req got %h exp 0", inst_req); end
        tick();
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick();
        inst_data_ok = 1'b0;
        settle();
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL rw_validF got %h exp 0", validF); end
        tests++; if (inst_req !== 1'b1) begin fails++; $display("FAIL rw_req2 got %h exp 1", inst_req); end
        tests++; if (inst_addr !== 32'h8000_0100) begin fails++; $display("FAIL rw_addr got %h exp 80000100", inst_addr); end
        fetch_word(32'h1111_2222, 1'b0);
        tests++; if (instrF !== 32'h1111_2222) begin fails++; $display("FAIL rw_instrF got %h exp 11112222", instrF); end
        tests++; if (pcF !== 32'h8000_0100) begin fails++; $display("FAIL rw_pcF got %h exp 80000100", pcF); end
    endtask

    task automatic test_redirect_data();
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3333_4444;
        pc_redirect = 1'b1; pc_target = 32'h8000_0200;
        tick();
        inst_data_ok = 1'b0; pc_redirect = 1'b0;
        settle();
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL rd_validF got %h exp 0", validF); end
        tests++; if (inst_req !== 1'b1) begin fails++; $display("FAIL rd_req got %h exp 1", inst_req); end
        tests++; if (inst_addr !== 32'h8000_0200) begin fails++; $display("FAIL rd_addr got %h exp 80000200", inst_addr); end
        pc_redirect = 1'b1; pc_target = 32'h8000_0300;
        settle();
        tests++; if (inst_req !== 1'b0) begin fails++; $display("FAIL idle_redir_req got %h exp 0", inst_req); end
        tick();
        pc_redirect = 1'b0;
        settle();
        tests++; if (inst_addr !== 32'h8000_0300) begin fails++; $display("FAIL idle_redir_addr got %h exp 80000300", inst_addr); end
        fetch_word(32'h5555_6666, 1'b1);
        tests++; if (validF !== 1'b1) begin fails++; $display("FAIL done_hold_validF got %h exp 1", validF); end
        pc_redirect = 1'b1; pc_target = 32'h8000_0400;
        tick();
        pc_redirect = 1'b0; stallF = 1'b0;
        settle();
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL done_redir_validF got %h exp 0", validF); end
        tests++; if (inst_addr !== 32'h8000_0400) begin fails++; $display("FAIL done_redir_addr got %h exp 80000400", inst_addr); end
        tests++; if (inst_req !== 1'b1) begin fails++; $display("FAIL done_redir_req got %h exp 1", inst_req); end
    endtask

    task automatic test_wrap();
        pc_redirect = 1'b1; pc_target = 32'hFFFF_FFFC;
        tick();
        pc_redirect = 1'b0;
        fetch_word(32'h7777_8888, 1'b0);
        tests++; if (pcF !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pcF got %h exp fffffffc", pcF); end
        tick();
        tests++; if (inst_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h exp 00000000", inst_addr); end
    endtask

    task automatic test_reset_wait();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL rstw_validF got %h exp 0", validF); end
        tests++; if (inst_req !== 1'b1) begin fails++; $display("FAIL rstw_req got %h exp 1", inst_req); end
        tests++; if (inst_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL rstw_addr got %h exp bfc00000", inst_addr); end
    endtask

    task automatic test_addr_err();
        pc_redirect = 1'b1; pc_target = 32'h8000_0102;
        tick();
        pc_redirect = 1'b0; stallF = 1'b1;
        settle();
`ifdef IF_ADDR_ERR_EN
        tests++; if (inst_req !== 1'b0) begin fails++; $display("FAIL adel_req got %h exp 0", inst_req); end
        tick();
        tests++; if (validF !== 1'b1) begin fails++; $display("FAIL adel_validF got %h exp 1", validF); end
        tests++; if (instrF !== 32'h0) begin fails++; $display("FAIL adel_instrF got %h exp 0", instrF); end
        tests++; if (adelF !== 1'b1) begin fails++; $display("FAIL adel_flag got %h exp 1", adelF); end
        tests++; if (pcF !== 32'h8000_0102) begin fails++; $display("FAIL adel_pcF got %h exp 80000102", pcF); end
`else
        tests++; if (inst_req !== 1'b1) begin fails++; $display("FAIL noadel_req got %h exp 1", inst_req); end
        tests++; if (inst_addr !== 32'h8000_0100) begin fails++; $display("FAIL noadel_addr got %h exp 80000100", inst_addr); end
        fetch_word(32'h9999_AAAA, 1'b1);
        tests++; if (adelF !== 1'b0) begin fails++; $display("FAIL noadel_flag got %h exp 0", adelF); end
        tests++; if (pcF !== 32'h8000_0102) begin fails++; $display("FAIL noadel_pcF got %h exp 80000102", pcF); end
`endif
        stallF = 1'b0;
        tick();
        tests++; if (validF !== 1'b0) begin fails++; $display("FAIL adel_release_validF got %h exp 0", validF); end
        tests++; if (adelF !== 1'b0) begin fails++; $display("FAIL adel_release_flag got %h exp 0", adelF); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_data();
        test_wrap();
        test_reset_wait();
        test_addr_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
